point_add_ext: RTL and testbench
================================

Name: point_add_ext

Overview:
- Responder side of the point-arithmetic handshake that the scalar multiplier drives.
- Performs one of three operations on twisted-Edwards points (a = -1, Ed25519) in extended coordinates (X:Y:Z:T), modulo P:
  - T-initialisation
  - unified addition (add-2008-hwcd-3)
  - doubling (dbl-2008-hwcd)
- Uses one internal bit-serial interleaved modular multiplier, reused for every product.

Parameters:
- W, 255, coordinate width in bits.
- P, 2^255-19, field modulus.
- D2, 16295367250680780974490674513165176452449235426866156013048779062215315747161, the constant 2d mod P.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  operation request; sampled only in IDLE.
- i_doubling  in  1  with i_start: compute 2*(P1); P2 inputs ignored.
- i_initial  in  1  with i_start: output (X1, Y1, Z1, X1*Y1); has priority over i_doubling.
- i_x1, i_y1, i_z1, i_t1  in  W each  operand P1.
- i_x2, i_y2, i_z2, i_t2  in  W each  operand P2.
- o_x3, o_y3, o_z3, o_t3  out  W each  result; held stable from o_finished until the next accepted start.
- o_finished  out  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; o_x3, o_y3, o_z3, o_t3 = 0; o_finished = 0. Reset mid-operation aborts the operation with no finished pulse.
- Acceptance:
  - i_start in IDLE latches all used inputs and the mode into internal registers.
  - Each latched value >= P is reduced by one subtraction of P, so P maps to 0. Inputs are guaranteed <= 2^255-1.
  - i_start outside IDLE is ignored; inputs may change freely after acceptance.
- States: IDLE -> LOAD -> MUL -> (LOAD ... ) -> DONE -> IDLE.
- Multiplier:
  - Per product: 1 LOAD cycle, then 255 MUL iterations, MSB first.
  - Each iteration: acc = 2*acc + (a_i ? b : 0), followed by up to two conditional subtractions of P, leaving acc in [0, P).
  - Product cost is exactly 256 cycles.
- Linear operations:
  - Modular add: a+b-P if a+b >= P. Modular sub: a-b+P if a < b.
  - Both are combinational and are evaluated in the LOAD cycle of the product that consumes them (operand forming) or that follows them (storing the previous product).
  - Add and sub add no extra cycles.
- Schedules (products in order):
  - initial: t = X1*Y1. Outputs are X1, Y1, Z1, t (1 product).
  - add (9 products):
    - Products: A = (Y1-X1)(Y2-X2), B = (Y1+X1)(Y2+X2), c = T1*T2, C = c*D2, Dz = Z1*Z2, then D = Dz+Dz.
    - Derived: E = B-A, F = D-C, G = D+C, H = B+A.
    - Outputs: X3 = E*F, Y3 = G*H, T3 = E*H, Z3 = F*G.
  - double (8 products):
    - Products: A = X1^2, B = Y1^2, z = Z1^2, then C = z+z; S = (X1+Y1)^2.
    - Derived: E = S-A-B, G = B-A, F = G-C, H = -(A+B) = P-(A+B) mod P.
    - Outputs: X3 = E*F, Y3 = G*H, T3 = E*H, Z3 = F*G.
- Latency: with i_start accepted in cycle 0, o_finished is high in cycle k*256+1, where k = 1, 9 or 8 for initial, add or double. Output registers update in that same cycle.
- The next i_start is accepted in the cycle after o_finished, which allows back-to-back chaining.
- All outputs are canonical, in [0, P). Both modes must agree with a reference model for any inputs, including the identity (0, 1, 1, 0) and P1 = P2.

Test Plan:
- initial, x1=3, y1=5, z1=1 -> o_x3=3, o_y3=5, o_z3=1, o_t3=15; o_finished pulses exactly at cycle 257.
- add of identity with itself (0, 1, 1, 0)+(0, 1, 1, 0) -> (X3, Y3, Z3, T3) = (0, 4, 4, 0); pulse at cycle 2305.
- double of (0, 1, 1, 0) -> (0, P-1, P-1, 0); pulse at cycle 2049.
- initial with x1=P, y1=7 (normalisation) -> o_x3=0, o_t3=0; initial with x1=y1=P-1 -> o_t3=1.
- Random base-point multiples: add(G, G) and double(G), both converted to affine, match the model. A second i_start pulsed mid-operation is ignored: exactly one o_finished, outputs unchanged.
- i_rst_n low during an add -> outputs 0 immediately, no pulse; after release, an initial with 3 and 5 completes correctly.

Source files
------------

// File: rtl/point_add_ext_if.sv
// Request/result bundle between the scalar multiplier (master) and the
// point-arithmetic responder (slave).
interface point_add_ext_if #(
   parameter int W = 255
);
   logic         i_start;
   logic         i_doubling;
   logic         i_initial;
   logic [W-1:0] i_x1;
   logic [W-1:0] i_y1;
   logic [W-1:0] i_z1;
   logic [W-1:0] i_t1;
   logic [W-1:0] i_x2;
   logic [W-1:0] i_y2;
   logic [W-1:0] i_z2;
   logic [W-1:0] i_t2;
   logic [W-1:0] o_x3;
   logic [W-1:0] o_y3;
   logic [W-1:0] o_z3;
   logic [W-1:0] o_t3;
   logic         o_finished;

   modport master (
      output i_start, i_doubling, i_initial,
      output i_x1, i_y1, i_z1, i_t1, i_x2, i_y2, i_z2, i_t2,
      input  o_x3, o_y3, o_z3, o_t3, o_finished
   );

   modport slave (
      input  i_start, i_doubling, i_initial,
      input  i_x1, i_y1, i_z1, i_t1, i_x2, i_y2, i_z2, i_t2,
      output o_x3, o_y3, o_z3, o_t3, o_finished
   );
endinterface

// File: rtl/point_add_ext.sv
// Twisted-Edwards (a = -1) extended-coordinate T-init / add / double over GF(2^255-19),
// built around one bit-serial interleaved modular multiplier shared by every product.
module point_add_ext #(
   parameter int           W  = 255,
   parameter logic [W-1:0] P  = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed,
   parameter logic [W-1:0] D2 = 255'd16295367250680780974490674513165176452449235426866156013048779062215315747161
) (
   input logic            i_clk,
   input logic            i_rst_n,
   point_add_ext_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;
   typedef enum logic [1:0] {MODE_INIT, MODE_ADD, MODE_DBL} mode_t;

   localparam logic [7:0] LAST_BIT = 8'(W - 1);

   function automatic logic [W-1:0] norm(input logic [W-1:0] v);
      return (v >= P) ? (v - P) : v;
   endfunction

   function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} - {1'b0, b};
      if (a < b) s = s + {1'b0, P};
      return s[W-1:0];
   endfunction

   // One MSB-first step: acc < P and b < P keep 2*acc + b below 3P, so two subtractions suffice.
   function automatic logic [W-1:0] mul_step(input logic [W-1:0] a_acc, input logic [W-1:0] b,
                                             input logic bit_in);
      logic [W+1:0] s;
      s = {1'b0, a_acc, 1'b0} + (bit_in ? {2'b00, b} : {(W+2){1'b0}});
      if (s >= {2'b00, P}) s = s - {2'b00, P};
      if (s >= {2'b00, P}) s = s - {2'b00, P};
      return s[W-1:0];
   endfunction

   state_t       state;
   state_t       state_next;
   mode_t        mode;
   logic [3:0]   step;
   logic [7:0]   cnt;

   logic [W-1:0] x1, y1, z1, t1, x2, y2, z2, t2;
   logic [W-1:0] ra, rb, rc, rd;
   logic [W-1:0] rx3, ry3, rt3;
   logic [W-1:0] mul_a, mul_b, acc;
   logic [W-1:0] x3, y3, z3, t3;

   logic [W-1:0] acc_next;
   logic [W-1:0] d_from_acc;
   logic [W-1:0] dval;
   logic [W-1:0] e_v, f_v, g_v, h_v;
   logic [W-1:0] op_a, op_b;
   logic [3:0]   last_step;
   logic [3:0]   out_base;
   logic         mul_last;

   assign acc_next  = mul_step(acc, mul_b, mul_a[W-1]);
   assign mul_last  = (state == MUL) && (cnt == 8'd0);
   assign last_step = (mode == MODE_INIT) ? 4'd0 : (mode == MODE_ADD) ? 4'd8 : 4'd7;
   assign out_base  = (mode == MODE_ADD) ? 4'd5 : 4'd4;

   // D (add) or S (double) is still sitting in acc during the LOAD of the first output product.
   assign d_from_acc = (mode == MODE_ADD) ? mod_add(acc, acc) : acc;
   assign dval       = (step == out_base) ? d_from_acc : rd;

   always_comb begin
      e_v = mod_sub(rb, ra);
      f_v = mod_sub(dval, rc);
      g_v = mod_add(dval, rc);
      h_v = mod_add(rb, ra);
      if (mode == MODE_DBL) begin
         e_v = mod_sub(mod_sub(dval, ra), rb);
         g_v = mod_sub(rb, ra);
         f_v = mod_sub(mod_sub(rb, ra), rc);
         h_v = mod_sub({W{1'b0}}, mod_add(ra, rb));
      end
   end

   always_comb begin
      op_a = x1;
      op_b = y1;
      if (mode == MODE_ADD) begin
         case (step)
            4'd0:    begin op_a = mod_sub(y1, x1); op_b = mod_sub(y2, x2); end
            4'd1:    begin op_a = mod_add(y1, x1); op_b = mod_add(y2, x2); end
            4'd2:    begin op_a = t1;              op_b = t2;              end
            4'd3:    begin op_a = acc;             op_b = D2;              end
            4'd4:    begin op_a = z1;              op_b = z2;              end
            4'd5:    begin op_a = e_v;             op_b = f_v;             end
            4'd6:    begin op_a = g_v;             op_b = h_v;             end
            4'd7:    begin op_a = e_v;             op_b = h_v;             end
            default: begin op_a = f_v;             op_b = g_v;             end
         endcase
      end else if (mode == MODE_DBL) begin
         case (step)
            4'd0:    begin op_a = x1;              op_b = x1;              end
            4'd1:    begin op_a = y1;              op_b = y1;              end
            4'd2:    begin op_a = z1;              op_b = z1;              end
            4'd3:    begin op_a = mod_add(x1, y1); op_b = mod_add(x1, y1); end
            4'd4:    begin op_a = e_v;             op_b = f_v;             end
            4'd5:    begin op_a = g_v;             op_b = h_v;             end
            4'd6:    begin op_a = e_v;             op_b = h_v;             end
            default: begin op_a = f_v;             op_b = g_v;             end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.i_start) state_next = LOAD;
         LOAD:    state_next = MUL;
         MUL:     if (cnt == 8'd0) state_next = (step == last_step) ? DONE : LOAD;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode <= MODE_INIT;
         step <= 4'd0;
         cnt  <= 8'd0;
         x3   <= '0;
         y3   <= '0;
         z3   <= '0;
         t3   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  mode <= bus.i_initial ? MODE_INIT : (bus.i_doubling ? MODE_DBL : MODE_ADD);
                  step <= 4'd0;
               end
            end
            LOAD: cnt <= LAST_BIT;
            MUL: begin
               cnt <= cnt - 8'd1;
               if (mul_last && step != last_step) step <= step + 4'd1;
               if (mul_last && step == last_step) begin
                  z3 <= (mode == MODE_INIT) ? z1 : acc_next;
                  t3 <= (mode == MODE_INIT) ? acc_next : rt3;
                  x3 <= (mode == MODE_INIT) ? x1 : rx3;
                  y3 <= (mode == MODE_INIT) ? y1 : ry3;
               end
            end
            default: ;
         endcase
      end
   end

   // Operand and product registers carry no reset; they are always written before use.
   always_ff @(posedge i_clk) begin
      if (state == IDLE && bus.i_start) begin
         x1 <= norm(bus.i_x1);
         y1 <= norm(bus.i_y1);
         z1 <= norm(bus.i_z1);
         t1 <= norm(bus.i_t1);
         x2 <= norm(bus.i_x2);
         y2 <= norm(bus.i_y2);
         z2 <= norm(bus.i_z2);
         t2 <= norm(bus.i_t2);
      end
      if (state == LOAD) begin
         mul_a <= op_a;
         mul_b <= op_b;
         acc   <= '0;
         if (mode != MODE_INIT && step != 4'd0) begin
            if (step == out_base)              rd  <= d_from_acc;
            else if (step == out_base + 4'd1)  rx3 <= acc;
            else if (step == out_base + 4'd2)  ry3 <= acc;
            else if (step == out_base + 4'd3)  rt3 <= acc;
            else begin
               case (step)
                  4'd1:    ra <= acc;
                  4'd2:    rb <= acc;
                  4'd3:    rc <= (mode == MODE_DBL) ? mod_add(acc, acc) : acc;
                  default: rc <= acc;
               endcase
            end
         end
      end
      if (state == MUL) begin
         acc   <= acc_next;
         mul_a <= {mul_a[W-2:0], 1'b0};
      end
   end

   assign bus.o_x3       = x3;
   assign bus.o_y3       = y3;
   assign bus.o_z3       = z3;
   assign bus.o_t3       = t3;
   assign bus.o_finished = (state == DONE);

endmodule

// File: tb/tb_point_add_ext.sv
// Randomised bench for point_add_ext: results compared with a field-arithmetic
// reference model (plain wide multiply/modulo) and with affine point equality.
module tb_point_add_ext;
   localparam int W = 255;
   typedef logic [W-1:0] fe_t;
   localparam fe_t P  = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
   localparam fe_t D2 = 255'd16295367250680780974490674513165176452449235426866156013048779062215315747161;
   localparam fe_t GX = 255'd15112221349535400772501151409588531511454012693041857206046113283949847762202;
   localparam fe_t GY = 255'd46316835694926478169428394003475163141307993866256225615783033603165251855960;

   typedef struct packed {
      fe_t x;
      fe_t y;
      fe_t z;
      fe_t t;
   } pt_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   point_add_ext_if #(.W(W)) bus ();

   point_add_ext #(.W(W), .P(P), .D2(D2)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input fe_t got, input fe_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic fe_t fred(input fe_t a);
      logic [W:0] r;
      r = {1'b0, a} % {1'b0, P};
      return r[W-1:0];
   endfunction

   function automatic fe_t mm(input fe_t a, input fe_t b);
      logic [2*W-1:0] pa, pb, pr;
      pa = {{W{1'b0}}, a};
      pb = {{W{1'b0}}, b};
      pr = (pa * pb) % {{W{1'b0}}, P};
      return pr[W-1:0];
   endfunction

   function automatic fe_t ma(input fe_t a, input fe_t b);
      logic [W:0] r;
      r = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
      return r[W-1:0];
   endfunction

   function automatic fe_t ms(input fe_t a, input fe_t b);
      logic [W:0] r;
      r = ({1'b0, a} + {1'b0, P} - {1'b0, b}) % {1'b0, P};
      return r[W-1:0];
   endfunction

   function automatic fe_t finv(input fe_t a);
      fe_t r, b, e;
      r = fe_t'(1);
      b = a;
      e = P - fe_t'(2);
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = mm(r, b);
         b = mm(b, b);
      end
      return r;
   endfunction

   function automatic pt_t mkpt(input fe_t x, input fe_t y, input fe_t z, input fe_t t);
      pt_t p;
      p.x = x; p.y = y; p.z = z; p.t = t;
      return p;
   endfunction

   function automatic pt_t aff(input pt_t p);
      fe_t zi;
      zi = finv(p.z);
      return mkpt(mm(p.x, zi), mm(p.y, zi), fe_t'(1), mm(p.t, zi));
   endfunction

   // mode: 0 = T-init, 1 = add, 2 = double
   function automatic pt_t ref_op(input int mode, input pt_t p1, input pt_t p2);
      fe_t x1, y1, z1, t1, x2, y2, z2, t2;
      fe_t a, b, c, d, s, e, f, g, h;
      x1 = fred(p1.x); y1 = fred(p1.y); z1 = fred(p1.z); t1 = fred(p1.t);
      x2 = fred(p2.x); y2 = fred(p2.y); z2 = fred(p2.z); t2 = fred(p2.t);
      if (mode == 0) return mkpt(x1, y1, z1, mm(x1, y1));
      if (mode == 1) begin
         a = mm(ms(y1, x1), ms(y2, x2));
         b = mm(ma(y1, x1), ma(y2, x2));
         c = mm(mm(t1, t2), D2);
         d = ma(mm(z1, z2), mm(z1, z2));
         e = ms(b, a); f = ms(d, c); g = ma(d, c); h = ma(b, a);
      end else begin
         a = mm(x1, x1);
         b = mm(y1, y1);
         c = ma(mm(z1, z1), mm(z1, z1));
         s = mm(ma(x1, y1), ma(x1, y1));
         e = ms(ms(s, a), b); g = ms(b, a); f = ms(g, c); h = ms(fe_t'(0), ma(a, b));
      end
      return mkpt(mm(e, f), mm(g, h), mm(f, g), mm(e, h));
   endfunction

   function automatic fe_t rnd_fe();
      logic [255:0] v;
      case ($urandom_range(0, 7))
         0: return P;
         1: return P - fe_t'(1);
         2: return {W{1'b1}};
         3: return fe_t'(0);
         default: begin
            for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
            return v[W-1:0];
         end
      endcase
   endfunction

   task automatic drive_req(input int mode, input pt_t p1, input pt_t p2);
      bus.i_initial  = (mode == 0);
      bus.i_doubling = (mode == 2);
      bus.i_x1 = p1.x; bus.i_y1 = p1.y; bus.i_z1 = p1.z; bus.i_t1 = p1.t;
      bus.i_x2 = p2.x; bus.i_y2 = p2.y; bus.i_z2 = p2.z; bus.i_t2 = p2.t;
   endtask

   task automatic scramble_inputs();
      bus.i_doubling = 1'($urandom_range(0, 1));
      bus.i_x1 = rnd_fe(); bus.i_y1 = rnd_fe(); bus.i_z1 = rnd_fe(); bus.i_t1 = rnd_fe();
      bus.i_x2 = rnd_fe(); bus.i_y2 = rnd_fe(); bus.i_z2 = rnd_fe(); bus.i_t2 = rnd_fe();
   endtask

   // Cycle 0 is the cycle in which i_start is sampled; cycle n follows n rising edges.
   task automatic run_op(input int mode, input pt_t p1, input pt_t p2, input int interfere,
                         input int limit, output int fin_cyc, output int pulses, output pt_t res);
      int cyc;
      @(posedge clk); #1;
      drive_req(mode, p1, p2);
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      scramble_inputs();
      cyc = 1; fin_cyc = -1; pulses = 0; res = '0;
      while (cyc <= limit) begin
         bus.i_start = (cyc == interfere);
         @(negedge clk);
         if (bus.o_finished === 1'b1) begin
            pulses++;
            if (fin_cyc < 0) begin
               fin_cyc = cyc;
               res = mkpt(bus.o_x3, bus.o_y3, bus.o_z3, bus.o_t3);
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.i_start = 1'b0;
   endtask

   task automatic do_case(input string tag, input int mode, input pt_t p1, input pt_t p2,
                          input int interfere, output pt_t res);
      int  fin, pulses, lat;
      pt_t exp;
      lat = (mode == 0) ? 257 : (mode == 1) ? 2305 : 2049;
      exp = ref_op(mode, p1, p2);
      run_op(mode, p1, p2, interfere, lat + 40, fin, pulses, res);
      check({tag, ".x3"}, res.x, exp.x);
      check({tag, ".y3"}, res.y, exp.y);
      check({tag, ".z3"}, res.z, exp.z);
      check({tag, ".t3"}, res.t, exp.t);
      check({tag, ".latency"}, fe_t'(fin), fe_t'(lat));
      check({tag, ".pulses"}, fe_t'(pulses), fe_t'(1));
      check({tag, ".hold_x3"}, bus.o_x3, exp.x);
      check({tag, ".hold_z3"}, bus.o_z3, exp.z);
   endtask

   initial begin
      pt_t res, q, g, r, ra, rb;
      pt_t idp;
      int  k, pulses, mode;

      bus.i_start = 1'b0;
      drive_req(1, '0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.x3", bus.o_x3, fe_t'(0));
      check("reset.y3", bus.o_y3, fe_t'(0));
      check("reset.t3", bus.o_t3, fe_t'(0));
      check("reset.finished", fe_t'(bus.o_finished), fe_t'(0));
      rst_n = 1'b1;

      do_case("init35", 0, mkpt(fe_t'(3), fe_t'(5), fe_t'(1), fe_t'(0)), '0, -1, res);
      check("init35.t3_const", res.t, fe_t'(15));

      idp = mkpt(fe_t'(0), fe_t'(1), fe_t'(1), fe_t'(0));
      do_case("add_id", 1, idp, idp, -1, res);
      check("add_id.y3_const", res.y, fe_t'(4));
      check("add_id.z3_const", res.z, fe_t'(4));
      do_case("dbl_id", 2, idp, idp, -1, res);
      check("dbl_id.y3_const", res.y, P - fe_t'(1));
      check("dbl_id.z3_const", res.z, P - fe_t'(1));

      do_case("init_p", 0, mkpt(P, fe_t'(7), fe_t'(1), fe_t'(0)), '0, -1, res);
      check("init_p.x3_const", res.x, fe_t'(0));
      check("init_p.t3_const", res.t, fe_t'(0));
      do_case("init_pm1", 0, mkpt(P - fe_t'(1), P - fe_t'(1), fe_t'(1), fe_t'(0)), '0, -1, res);
      check("init_pm1.t3_const", res.t, fe_t'(1));

      // k*G with projective Z != 1; both add(Q,Q) and double(Q) must land on 2k*G.
      g = mkpt(GX, GY, fe_t'(1), mm(GX, GY));
      k = $urandom_range(1, 4);
      q = g;
      for (int i = 1; i < k; i++) q = ref_op(1, q, g);
      r = g;
      for (int i = 1; i < 2 * k; i++) r = ref_op(1, r, g);
      ra = aff(r);
      do_case("gadd", 1, q, q, 1000, res);
      rb = aff(res);
      check("gadd.affine_x", rb.x, ra.x);
      check("gadd.affine_y", rb.y, ra.y);
      do_case("gdbl", 2, q, q, 700, res);
      rb = aff(res);
      check("gdbl.affine_x", rb.x, ra.x);
      check("gdbl.affine_y", rb.y, ra.y);

      for (int n = 0; n < 8; n++) begin
         mode = $urandom_range(0, 2);
         do_case($sformatf("rand%0d_m%0d", n, mode), mode,
                 mkpt(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe()),
                 mkpt(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe()), -1, res);
      end

      // Abort an add with reset; outputs must clear at once and no pulse may follow.
      do_case("pre_rst", 0, mkpt(fe_t'(3), fe_t'(5), fe_t'(1), fe_t'(0)), '0, -1, res);
      @(posedge clk); #1;
      drive_req(1, g, g);
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      repeat (500) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort.x3", bus.o_x3, fe_t'(0));
      check("abort.y3", bus.o_y3, fe_t'(0));
      check("abort.finished", fe_t'(bus.o_finished), fe_t'(0));
      pulses = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (bus.o_finished === 1'b1) pulses++;
      end
      check("abort.no_pulse", fe_t'(pulses), fe_t'(0));
      do_case("post_rst", 0, mkpt(fe_t'(3), fe_t'(5), fe_t'(1), fe_t'(0)), '0, -1, res);
      check("post_rst.t3_const", res.t, fe_t'(15));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
